// File: rtl/select_decode_if.sv
// Control/data bundle between the miniSRC control unit and the register-select decoder.
// The master drives IR load and select controls; the slave returns IR fields and enables.
interface select_decode_if;
  logic [31:0] BusMuxOut;
  logic        IRin;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic [31:0] IR_q;
  logic [4:0]  opcode;
  logic [31:0] C_sext;
  logic [15:0] Rin_en;
  logic [15:0] Rout_en;
  logic        R0_zero;
  logic        sel_err;

  modport master (
    output BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
    input  IR_q, opcode, C_sext, Rin_en, Rout_en, R0_zero, sel_err
  );

  modport slave (
    input  BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
    output IR_q, opcode, C_sext, Rin_en, Rout_en, R0_zero, sel_err
  );
endinterface

// File: rtl/select_decode_unit.sv
// miniSRC register-select decoder: holds IR, decodes Ra/Rb/Rc into registered one-hot
// R0-R15 write/read enables, and latches a sticky flag on illegal select/control mixes.
module select_decode_unit (
  input  logic           clk,
  input  logic           clr,
  select_decode_if.slave bus
);

  logic [31:0] r_ir;
  logic [15:0] r_rin_en;
  logic [15:0] r_rout_en;
  logic        r_r0_zero;
  logic        r_sel_err;

  logic [3:0]  w_field;
  logic [15:0] w_onehot;
  logic        w_sel_any;
  logic        w_sel_multi;
  logic        w_ctl_any;
  logic        w_illegal;
  logic        w_field_nz;
  logic [15:0] w_rin_nxt;
  logic [15:0] w_rout_nxt;
  logic        w_r0_zero_nxt;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  // Instruction register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ir <= 32'h0000_0000;
    end else if (bus.IRin) begin
      r_ir <= bus.BusMuxOut;
    end else begin
      r_ir <= r_ir;
    end
  end

  // Field mux and decode of the next enable values
  always_comb begin
    w_field       = 4'h0;
    w_sel_any     = 1'b0;
    w_sel_multi   = 1'b0;
    w_ctl_any     = 1'b0;
    w_illegal     = 1'b0;
    w_field_nz    = 1'b0;
    w_onehot      = 16'h0000;
    w_rin_nxt     = 16'h0000;
    w_rout_nxt    = 16'h0000;
    w_r0_zero_nxt = 1'b0;

    w_field = ({4{bus.Gra}} & r_ir[26:23]) |
              ({4{bus.Grb}} & r_ir[22:19]) |
              ({4{bus.Grc}} & r_ir[18:15]);
    w_sel_any   = bus.Gra | bus.Grb | bus.Grc;
    w_sel_multi = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc);
    w_ctl_any   = bus.Rin | bus.Rout | bus.BAout;
    w_illegal   = w_ctl_any & (w_sel_multi | ~w_sel_any);
    w_field_nz  = (w_field != 4'h0);
    w_onehot    = w_sel_any ? onehot16(w_field) : 16'h0000;

    // An illegal cycle forces every enable low so no two sources can drive the bus
    if (w_illegal) begin
      w_rin_nxt     = 16'h0000;
      w_rout_nxt    = 16'h0000;
      w_r0_zero_nxt = 1'b0;
    end else begin
      w_rin_nxt     = bus.Rin ? w_onehot : 16'h0000;
      w_rout_nxt    = (bus.Rout | (bus.BAout & w_field_nz)) ? w_onehot : 16'h0000;
      w_r0_zero_nxt = bus.BAout & ~w_field_nz & w_sel_any & ~bus.Rout;
    end
  end

  // Registered enables and sticky error flag
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_rin_en  <= 16'h0000;
      r_rout_en <= 16'h0000;
      r_r0_zero <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_rin_en  <= w_rin_nxt;
      r_rout_en <= w_rout_nxt;
      r_r0_zero <= w_r0_zero_nxt;
      r_sel_err <= r_sel_err | w_illegal;
    end
  end

  assign bus.IR_q    = r_ir;
  assign bus.opcode  = r_ir[31:27];
  assign bus.C_sext  = {{13{r_ir[18]}}, r_ir[18:0]};
  assign bus.Rin_en  = r_rin_en;
  assign bus.Rout_en = r_rout_en;
  assign bus.R0_zero = r_r0_zero;
  assign bus.sel_err = r_sel_err;

endmodule

// File: tb/tb_select_decode_unit.sv
// Directed-vector bench for select_decode_unit; expected values are hand-computed from
// the IR field layout (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]).
module tb_select_decode_unit;
  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  select_decode_if bus ();

  select_decode_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (obs !== exp_v) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.IRin  = 1'b0;
    bus.Gra   = 1'b0;
    bus.Grb   = 1'b0;
    bus.Grc   = 1'b0;
    bus.Rin   = 1'b0;
    bus.Rout  = 1'b0;
    bus.BAout = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] v);
    idle();
    bus.BusMuxOut = v;
    bus.IRin      = 1'b1;
    tick();
    bus.IRin = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    clr           = 1'b1;
    bus.BusMuxOut = 32'h0000_0000;
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ir", bus.IR_q, 32'h0);
    chk("rst_rin", {16'h0, bus.Rin_en}, 32'h0);
    chk("rst_rout", {16'h0, bus.Rout_en}, 32'h0);
    chk("rst_err", {31'h0, bus.sel_err}, 32'h0);
    clr = 1'b0;

    // Rc write, Rb read with IR = 1A98_0000 (opcode 3, Ra 5, Rb 3, Rc 0)
    load_ir(32'h1A98_0000);
    chk("ir_load", bus.IR_q, 32'h1A98_0000);
    chk("opcode", {27'h0, bus.opcode}, 32'h3);
    bus.Grc = 1'b1; bus.Rin = 1'b1;
    tick();
    chk("rc_rin", {16'h0, bus.Rin_en}, 32'h0001);
    chk("rc_rout", {16'h0, bus.Rout_en}, 32'h0000);
    idle();
    bus.Grb = 1'b1; bus.Rout = 1'b1;
    tick();
    chk("rb_rout", {16'h0, bus.Rout_en}, 32'h0008);
    chk("rin_pulse", {16'h0, bus.Rin_en}, 32'h0000);
    idle();
    tick();
    chk("rout_pulse", {16'h0, bus.Rout_en}, 32'h0000);

    // Rin and Rout together on Ra
    bus.Gra = 1'b1; bus.Rin = 1'b1; bus.Rout = 1'b1;
    tick();
    chk("both_rin", {16'h0, bus.Rin_en}, 32'h0020);
    chk("both_rout", {16'h0, bus.Rout_en}, 32'h0020);
    chk("both_err", {31'h0, bus.sel_err}, 32'h0);

    // Base addressing: Rb = 0, then Rb = 7, then Rout overriding BAout
    load_ir(32'h0080_0000);
    bus.Grb = 1'b1; bus.BAout = 1'b1;
    tick();
    chk("ba0_rout", {16'h0, bus.Rout_en}, 32'h0000);
    chk("ba0_zero", {31'h0, bus.R0_zero}, 32'h1);
    bus.Rout = 1'b1;
    tick();
    chk("ba0rout_rout", {16'h0, bus.Rout_en}, 32'h0001);
    chk("ba0rout_zero", {31'h0, bus.R0_zero}, 32'h0);
    load_ir(32'h0038_0000);
    chk("ba_zero_clr", {31'h0, bus.R0_zero}, 32'h0);
    bus.Grb = 1'b1; bus.BAout = 1'b1;
    tick();
    chk("ba7_rout", {16'h0, bus.Rout_en}, 32'h0080);
    chk("ba7_zero", {31'h0, bus.R0_zero}, 32'h0);

    // Sign extension of C
    load_ir(32'h0004_0001);
    chk("csext_neg", bus.C_sext, 32'hFFFC_0001);
    load_ir(32'h0003_FFFF);
    chk("csext_pos", bus.C_sext, 32'h0003_FFFF);

    // IR load and decode on the same edge use the old Ra
    load_ir(32'h0100_0000);
    bus.BusMuxOut = 32'h0480_0000;
    bus.IRin = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
    tick();
    chk("same_edge", {16'h0, bus.Rin_en}, 32'h0004);
    chk("same_edge_ir", bus.IR_q, 32'h0480_0000);
    bus.IRin = 1'b0;
    tick();
    chk("next_edge", {16'h0, bus.Rin_en}, 32'h0200);

    // Illegal controls and sticky flag
    idle();
    bus.Gra = 1'b1; bus.Grb = 1'b1; bus.Rout = 1'b1;
    tick();
    chk("ill_rout", {16'h0, bus.Rout_en}, 32'h0000);
    chk("ill_err", {31'h0, bus.sel_err}, 32'h1);
    idle();
    bus.Rin = 1'b1;
    tick();
    chk("nosel_rin", {16'h0, bus.Rin_en}, 32'h0000);
    idle();
    bus.Gra = 1'b1; bus.Rin = 1'b1;
    tick();
    chk("legal_after", {16'h0, bus.Rin_en}, 32'h0200);
    chk("err_sticky", {31'h0, bus.sel_err}, 32'h1);

    // Async clear mid-cycle while Rin_en = 0008
    load_ir(32'h1A98_0000);
    bus.Grb = 1'b1; bus.Rin = 1'b1;
    tick();
    chk("pre_rst_rin", {16'h0, bus.Rin_en}, 32'h0008);
    idle();
    #2;
    clr = 1'b1;
    #1;
    chk("arst_rin", {16'h0, bus.Rin_en}, 32'h0000);
    chk("arst_ir", bus.IR_q, 32'h0);
    chk("arst_csext", bus.C_sext, 32'h0);
    chk("arst_err", {31'h0, bus.sel_err}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    tick();
    chk("post_rst_err", {31'h0, bus.sel_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
